// File: rtl/nibble_adder_pkg.sv
// nibble_adder_pkg: shared state encodings and slice width for the sequential nibble adder
package nibble_adder_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   localparam int NIB_BITS = 4;
endpackage

// File: rtl/par_4bit_add.sv
// par_4bit_add: 4-bit parallel adder slice with carry in and carry out
module par_4bit_add (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);
endmodule

// File: rtl/nibble_seq_adder.sv
// nibble_seq_adder: WIDTH-bit adder that processes one nibble per clock, LSB first
module nibble_seq_adder
   import nibble_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int NIB = WIDTH / NIB_BITS;
   localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
   state_t state, nxt;
   logic [WIDTH-1:0] ra, rb, acc, acc_nxt, sa, sb;
   logic [IW-1:0] idx;
   logic [NIB_BITS-1:0] s_sum;
   logic carry, s_cout, last, accept;
   assign sa     = ra >> (NIB_BITS * idx);
   assign sb     = rb >> (NIB_BITS * idx);
   assign last   = idx == IW'(NIB - 1);
   assign accept = start && (state == IDLE || state == DONE);
   assign busy   = state == RUN;
   assign done   = state == DONE;
   par_4bit_add u_slice (
      .a   (sa[NIB_BITS-1:0]),
      .b   (sb[NIB_BITS-1:0]),
      .cin (carry),
      .sum (s_sum),
      .cout(s_cout)
   );
   // accumulator with the current slice result merged in, so the final edge can publish it directly
   always_comb begin
      acc_nxt = acc;
      acc_nxt[NIB_BITS*idx +: NIB_BITS] = s_sum;
   end
   always_comb begin
      nxt = accept ? RUN : (state == RUN ? (last ? DONE : RUN) : IDLE);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ra    <= '0;
         rb    <= '0;
         carry <= 1'b0;
         idx   <= '0;
         acc   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         ra    <= a;
         rb    <= b;
         carry <= cin;
         idx   <= '0;
         acc   <= '0;
      end else if (state == RUN) begin
         acc   <= acc_nxt;
         carry <= s_cout;
         idx   <= last ? '0 : idx + 1'b1;
         if (last) begin
            sum  <= acc_nxt;
            cout <= s_cout;
         end
      end
   end
endmodule
